// File: rtl/router_pkg.sv
// Shared mesh-router definitions: packet width, field positions and
// the Y-hop decrement helper used on link entry.
package router_pkg;

  localparam int PKT_W  = 16;
  localparam int DX_MSB = 15;
  localparam int DX_LSB = 12;
  localparam int DY_MSB = 11;
  localparam int DY_LSB = 8;
  localparam int PL_MSB = 7;
  localparam int PL_LSB = 0;

  // Returns the packet with its dy field reduced by one hop.
  // dx and payload pass through untouched.
  function automatic logic [PKT_W-1:0] dec_dy(input logic [PKT_W-1:0] pkt);
    logic [PKT_W-1:0] res;
    res = pkt;
    res[DY_MSB:DY_LSB] = pkt[DY_MSB:DY_LSB] - 4'd1;
    return res;
  endfunction

endpackage

// File: rtl/slr_fifo.sv
// Generic synchronous FIFO with first-word fall-through read.
// DEPTH must be a power of two so the pointers wrap naturally;
// occupancy is kept in a separate counter to tell full from empty.
module slr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A full FIFO refuses writes even when a read frees a slot this cycle,
  // keeping the write-side ready free of any path from the read side.
  assign push = wr_en_i && !full_o;
  assign pop  = rd_en_i && !empty_o;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/south_link_receiver.sv
// Receive end of the north->south mesh link. Buffers incoming packets,
// consumes one Y hop on entry and presents them with valid/ready.
// Optional feature: define SLR_DROP_CNT_EN to build the saturating
// dropped-packet counter; otherwise drop_cnt reads as zero.
module south_link_receiver #(
  parameter int DEPTH = 4,
  parameter int PKT_W = router_pkg::PKT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PKT_W-1:0]         packet_in,
  input  logic                     valid_in,
  output logic                     ready_in,
  output logic [PKT_W-1:0]         packet_out,
  output logic                     valid_out,
  input  logic                     ready_out,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     hop_err,
  output logic [7:0]               drop_cnt
);

  logic             fifo_full, fifo_empty;
  logic             push;
  logic             dy_zero;
  logic [PKT_W-1:0] wr_pkt;
  logic             hop_err_q, hop_err_d;

  assign ready_in  = !fifo_full;
  assign valid_out = !fifo_empty;
  assign push      = valid_in && ready_in;
  assign dy_zero   = (packet_in[router_pkg::DY_MSB:router_pkg::DY_LSB] == '0);

  // A packet arriving with no hops left is stored as-is rather than wrapping dy.
  assign wr_pkt    = dy_zero ? packet_in : router_pkg::dec_dy(packet_in);
  assign hop_err_d = push && dy_zero;
  assign hop_err   = hop_err_q;

  slr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PKT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (valid_in),
    .wr_data_i (wr_pkt),
    .rd_en_i   (ready_out),
    .rd_data_o (packet_out),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (occupancy)
  );

  // Registered one-cycle pulse for a zero-dy packet accepted last cycle.
  always_ff @(posedge clk) begin
    if (rst) hop_err_q <= 1'b0;
    else     hop_err_q <= hop_err_d;
  end

`ifdef SLR_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign drop_cnt_d = (valid_in && !ready_in && drop_cnt_q != 8'hFF)
                      ? drop_cnt_q + 8'd1 : drop_cnt_q;
  assign drop_cnt   = drop_cnt_q;

  // Saturating count of packets offered while full; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= 8'h00;
    else     drop_cnt_q <= drop_cnt_d;
  end
`else
  assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_south_link_receiver.sv
// Directed-vector bench for south_link_receiver.
module tb_south_link_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] packet_in;
  logic        valid_in;
  logic        ready_in;
  logic [15:0] packet_out;
  logic        valid_out;
  logic        ready_out;
  logic [2:0]  occupancy;
  logic        hop_err;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_drop;

  always #5 clk = ~clk;

  south_link_receiver #(.DEPTH(4), .PKT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .packet_in  (packet_in),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .packet_out (packet_out),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .occupancy  (occupancy),
    .hop_err    (hop_err),
    .drop_cnt   (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] pkt);
    packet_in = pkt;
    valid_in  = 1'b1;
    step();
    valid_in  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp);
    check({tag, "_valid"}, valid_out, 1);
    check(tag, packet_out, exp);
    ready_out = 1'b1;
    step();
    ready_out = 1'b0;
  endtask

  initial begin
    rst = 1'b1; packet_in = '0; valid_in = 1'b0; ready_out = 1'b0;
    exp_drop = 8'd0;
    repeat (2) step();
    rst = 1'b0;
    check("rst_valid_out", valid_out, 0);
    check("rst_ready_in", ready_in, 1);
    check("rst_occupancy", occupancy, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_hop_err", hop_err, 0);

    // single packet, held stable while not accepted
    push(16'h0312);
    check("t2_valid", valid_out, 1);
    check("t2_pkt", packet_out, 16'h0212);
    check("t2_occ", occupancy, 1);
    check("t2_hop_err", hop_err, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_stable", packet_out, 16'h0212);
    end
    pop_check("t2_pop", 16'h0212);
    check("t2_empty", valid_out, 0);
    check("t2_occ0", occupancy, 0);

    // fill, overflow drop, drain in order
    push(16'h0100); push(16'h0200); push(16'h0300); push(16'h0400);
    check("t3_ready_full", ready_in, 0);
    check("t3_occ_full", occupancy, 4);
    push(16'h0F00);
`ifdef SLR_DROP_CNT_EN
    exp_drop = 8'd1;
`endif
    check("t3_occ_after_drop", occupancy, 4);
    check("t3_drop_cnt", drop_cnt, {24'd0, exp_drop});
    pop_check("t3_d0", 16'h0000);
    pop_check("t3_d1", 16'h0100);
    pop_check("t3_d2", 16'h0200);
    pop_check("t3_d3", 16'h0300);
    check("t3_occ0", occupancy, 0);

    // full with simultaneous pop and push: push refused, then accepted
    push(16'h0111); push(16'h0122); push(16'h0133); push(16'h0144);
    packet_in = 16'h0255; valid_in = 1'b1; ready_out = 1'b1;
    step();
    ready_out = 1'b0;
`ifdef SLR_DROP_CNT_EN
    exp_drop = 8'd2;
`endif
    check("t4_occ3", occupancy, 3);
    check("t4_ready", ready_in, 1);
    check("t4_head", packet_out, 16'h0022);
    step();
    valid_in = 1'b0;
    check("t4_occ4", occupancy, 4);
    check("t4_drop_cnt", drop_cnt, {24'd0, exp_drop});
    pop_check("t4_d0", 16'h0022);
    pop_check("t4_d1", 16'h0033);
    pop_check("t4_d2", 16'h0044);
    pop_check("t4_d3", 16'h0155);

    // zero-dy packet: stored unchanged, one-cycle hop_err
    push(16'h1000);
    check("t5_hop_err", hop_err, 1);
    check("t5_pkt", packet_out, 16'h1000);
    step();
    check("t5_hop_err_clr", hop_err, 0);
    pop_check("t5_pop", 16'h1000);

    // streaming with ready_out high, reset mid-stream
    ready_out = 1'b1;
    for (int i = 0; i < 6; i++) begin
      packet_in = {8'h25, 8'(i)}; valid_in = 1'b1;
      step();
      check("t6_stream", packet_out, {8'h24, 8'(i)});
      check("t6_occ", occupancy, 1);
    end
    rst = 1'b1; packet_in = 16'h25AA;
    step();
    rst = 1'b0;
    check("t6_rst_valid", valid_out, 0);
    check("t6_rst_occ", occupancy, 0);
    check("t6_rst_ready", ready_in, 1);
    check("t6_rst_drop", drop_cnt, 0);
    for (int i = 6; i < 10; i++) begin
      packet_in = {8'h25, 8'(i)}; valid_in = 1'b1;
      step();
      check("t6_stream2", packet_out, {8'h24, 8'(i)});
      check("t6_valid2", valid_out, 1);
    end
    valid_in = 1'b0;
    step();
    ready_out = 1'b0;
    check("t6_end_occ", occupancy, 0);
    check("t6_end_valid", valid_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
